// File: rtl/stack_pkg.sv
// Shared types and default geometry for the
// stack controller and its pointer unit.
package stack_pkg;

    localparam int STK_DATA_W = 10;
    localparam int STK_ADDR_W = 8;
    localparam logic [STK_ADDR_W-1:0] STK_SP_RESET = 8'h00;
    localparam int STK_DEPTH = 1 << STK_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

endpackage

// File: rtl/stack_ctrl_if.sv
// Requester-side bundle of the stack controller:
// push/pop/load requests and their responses.
interface stack_ctrl_if
    import stack_pkg::*;
#(
    parameter int DATA_W = STK_DATA_W,
    parameter int ADDR_W = STK_ADDR_W
);

    logic              PUSH_REQ;
    logic [DATA_W-1:0] PUSH_DATA;
    logic              POP_REQ;
    logic              SP_LD;
    logic [ADDR_W-1:0] SP_DIN;
    logic              BUSY;
    logic              ACK;
    logic [DATA_W-1:0] POP_DATA;
    logic              POP_VALID;
    logic [ADDR_W-1:0] SP_OUT;
    logic              FULL;
    logic              EMPTY;
    logic              OVF;
    logic              UNF;

    modport master (
        output PUSH_REQ, PUSH_DATA, POP_REQ, SP_LD, SP_DIN,
        input  BUSY, ACK, POP_DATA, POP_VALID, SP_OUT,
        input  FULL, EMPTY, OVF, UNF
    );

    modport slave (
        input  PUSH_REQ, PUSH_DATA, POP_REQ, SP_LD, SP_DIN,
        output BUSY, ACK, POP_DATA, POP_VALID, SP_OUT,
        output FULL, EMPTY, OVF, UNF
    );

endinterface

// File: rtl/stack_ptr.sv
// Stack pointer and occupancy counter. dec is a push
// (SP down, count up), inc is a pop (SP up, count down).
module stack_ptr
    import stack_pkg::*;
#(
    parameter int ADDR_W = STK_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(STK_SP_RESET)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] din,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] sp,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] SP_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    logic [ADDR_W:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= SP_RESET;
            cnt <= '0;
        end else if (load) begin
            sp  <= din;
            cnt <= '0;
        end else if (dec) begin
            sp  <= sp - SP_ONE;
            cnt <= cnt + CNT_ONE;
        end else if (inc) begin
            sp  <= sp + SP_ONE;
            cnt <= cnt - CNT_ONE;
        end
    end

    // count never exceeds 2**ADDR_W, so the top bit alone means full
    assign full  = cnt[ADDR_W];
    assign empty = (cnt == '0);

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller owning the scratch RAM port:
// sequences push writes and pop reads for the control unit.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = STK_DATA_W,
    parameter int ADDR_W = STK_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(STK_SP_RESET)
) (
    input  logic              CLK,
    input  logic              RST_N,
    stack_ctrl_if.slave       bus,
    output logic [ADDR_W-1:0] SCR_ADDR,
    output logic              SCR_WE,
    output logic [DATA_W-1:0] SCR_DATA_OUT,
    input  logic [DATA_W-1:0] SCR_DATA_IN
);

    localparam logic [ADDR_W-1:0] SP_ONE = 1;

    state_t            state, next;
    logic [DATA_W-1:0] wdata_q, pop_q;
    logic              ovf_q, unf_q;
    logic              ld, sp_inc, sp_dec, cap_w, ovf_d, unf_d;
    logic [ADDR_W-1:0] sp;
    logic              full, empty;

    stack_ptr #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_ptr (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (ld),
        .din   (bus.SP_DIN),
        .inc   (sp_inc),
        .dec   (sp_dec),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdata_q <= '0;
            pop_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (cap_w)         wdata_q <= bus.PUSH_DATA;
            if (state == READ) pop_q   <= SCR_DATA_IN;
        end
    end

    always_comb begin
        next   = state;
        ld     = 1'b0;
        sp_inc = 1'b0;
        sp_dec = 1'b0;
        cap_w  = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.SP_LD) begin
                    ld = 1'b1;
                end else if (bus.PUSH_REQ) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        cap_w = 1'b1;
                        next  = WRITE;
                    end
                end else if (bus.POP_REQ) begin
                    if (empty) unf_d = 1'b1;
                    else       next  = READ;
                end
            end
            WRITE: begin
                sp_dec = 1'b1;
                next   = IDLE;
            end
            READ: begin
                sp_inc = 1'b1;
                next   = RESP;
            end
            RESP: next = IDLE;
            default: next = IDLE;
        endcase
    end

    // push pre-decrements: the write lands one below the current SP
    assign SCR_ADDR      = (state == WRITE) ? sp - SP_ONE : sp;
    assign SCR_WE        = (state == WRITE);
    assign SCR_DATA_OUT  = wdata_q;

    assign bus.BUSY      = (state != IDLE);
    assign bus.ACK       = (state == WRITE) || (state == RESP);
    assign bus.POP_VALID = (state == RESP);
    assign bus.POP_DATA  = pop_q;
    assign bus.SP_OUT    = sp;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.OVF       = ovf_q;
    assign bus.UNF       = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl against a queue-based
// stack model; the scratch RAM lives in the bench.
module tb_stack_ctrl;
    import stack_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] scr_addr;
    logic       scr_we;
    logic [9:0] scr_dout;
    logic [9:0] scr_din;
    logic [9:0] ram [256];

    int n_run = 0;
    int n_fail = 0;
    int stk[$];
    int m_sp = 0;

    always #5 CLK = ~CLK;

    stack_ctrl_if bus ();

    stack_ctrl dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .bus          (bus.slave),
        .SCR_ADDR     (scr_addr),
        .SCR_WE       (scr_we),
        .SCR_DATA_OUT (scr_dout),
        .SCR_DATA_IN  (scr_din)
    );

    always @(posedge CLK) if (scr_we) ram[scr_addr] <= scr_dout;
    assign scr_din = ram[scr_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_chk();
        chk("idle_busy", 32'(bus.BUSY), 0);
        chk("idle_sp", 32'(bus.SP_OUT), m_sp);
        chk("idle_addr", 32'(scr_addr), m_sp);
        chk("idle_we", 32'(scr_we), 0);
        chk("idle_empty", 32'(bus.EMPTY), stk.size() == 0);
        chk("idle_full", 32'(bus.FULL), stk.size() == 256);
    endtask

    task automatic t_push(input int d);
        bus.PUSH_REQ = 1'b1;
        bus.PUSH_DATA = 10'(d);
        @(negedge CLK);
        if (stk.size() == 256) begin
            chk("ovf_hi", 32'(bus.OVF), 1);
            chk("ovf_busy", 32'(bus.BUSY), 0);
            chk("ovf_we", 32'(scr_we), 0);
            chk("ovf_ack", 32'(bus.ACK), 0);
            bus.PUSH_REQ = 1'b0;
            @(negedge CLK);
            chk("ovf_lo", 32'(bus.OVF), 0);
        end else begin
            chk("wr_we", 32'(scr_we), 1);
            chk("wr_addr", 32'(scr_addr), (m_sp - 1) & 255);
            chk("wr_data", 32'(scr_dout), d);
            chk("wr_ack", 32'(bus.ACK), 1);
            chk("wr_busy", 32'(bus.BUSY), 1);
            bus.PUSH_REQ = 1'b0;
            m_sp = (m_sp - 1) & 255;
            stk.push_front(d);
            @(negedge CLK);
            chk("wr_ack_lo", 32'(bus.ACK), 0);
        end
        idle_chk();
    endtask

    task automatic t_pop();
        int e;
        bus.POP_REQ = 1'b1;
        @(negedge CLK);
        if (stk.size() == 0) begin
            chk("unf_hi", 32'(bus.UNF), 1);
            chk("unf_busy", 32'(bus.BUSY), 0);
            chk("unf_ack", 32'(bus.ACK), 0);
            bus.POP_REQ = 1'b0;
            @(negedge CLK);
            chk("unf_lo", 32'(bus.UNF), 0);
        end else begin
            chk("rd_busy", 32'(bus.BUSY), 1);
            chk("rd_we", 32'(scr_we), 0);
            chk("rd_addr", 32'(scr_addr), m_sp);
            chk("rd_ack", 32'(bus.ACK), 0);
            bus.POP_REQ = 1'b0;
            @(negedge CLK);
            e = stk.pop_front();
            m_sp = (m_sp + 1) & 255;
            chk("resp_ack", 32'(bus.ACK), 1);
            chk("resp_valid", 32'(bus.POP_VALID), 1);
            chk("resp_data", 32'(bus.POP_DATA), e);
            @(negedge CLK);
            chk("post_valid", 32'(bus.POP_VALID), 0);
            chk("post_data", 32'(bus.POP_DATA), e);
        end
        idle_chk();
    endtask

    // push and pop together: push wins, pop follows from IDLE
    task automatic t_both(input int d);
        bus.POP_REQ = 1'b1;
        bus.PUSH_REQ = 1'b1;
        bus.PUSH_DATA = 10'(d);
        @(negedge CLK);
        chk("both_we", 32'(scr_we), 1);
        chk("both_data", 32'(scr_dout), d);
        bus.PUSH_REQ = 1'b0;
        m_sp = (m_sp - 1) & 255;
        stk.push_front(d);
        @(negedge CLK);
        chk("both_sp", 32'(bus.SP_OUT), m_sp);
        t_pop();
    endtask

    task automatic t_load(input int v);
        bus.SP_LD = 1'b1;
        bus.SP_DIN = 8'(v);
        @(negedge CLK);
        bus.SP_LD = 1'b0;
        m_sp = v;
        stk.delete();
        chk("ld_ack", 32'(bus.ACK), 0);
        idle_chk();
    endtask

    initial begin
        logic [9:0] old;
        int r;
        bus.PUSH_REQ = 1'b0;
        bus.PUSH_DATA = '0;
        bus.POP_REQ = 1'b0;
        bus.SP_LD = 1'b0;
        bus.SP_DIN = '0;
        repeat (2) @(negedge CLK);
        chk("rst_sp", 32'(bus.SP_OUT), 0);
        chk("rst_addr", 32'(scr_addr), 0);
        chk("rst_we", 32'(scr_we), 0);
        chk("rst_dout", 32'(scr_dout), 0);
        chk("rst_pdata", 32'(bus.POP_DATA), 0);
        chk("rst_ack", 32'(bus.ACK), 0);
        chk("rst_flags", 32'({bus.POP_VALID, bus.OVF, bus.UNF}), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_empty", 32'(bus.EMPTY), 1);
        RST_N = 1'b1;
        @(negedge CLK);

        t_pop();
        t_push(10'h155);
        t_push(10'h2AA);
        t_push(10'h3FF);
        chk("three_sp", 32'(bus.SP_OUT), 8'hFD);
        repeat (3) t_pop();
        chk("drain_sp", 32'(bus.SP_OUT), 0);

        t_push(10'h0AB);
        t_both(10'h1CD);
        t_pop();

        t_load(0);
        for (int i = 0; i < 256; i++) t_push(int'($urandom_range(0, 1023)));
        chk("full", 32'(bus.FULL), 1);
        t_push(10'h111);
        chk("ovf_sp", 32'(bus.SP_OUT), 0);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 8)       t_push(int'($urandom_range(0, 1023)));
            else if (r < 16) t_pop();
            else if (r < 19 && stk.size() < 256)
                t_both(int'($urandom_range(0, 1023)));
            else if (r == 19) t_load(int'($urandom_range(0, 255)));
        end

        t_load(8'h40);
        chk("ld40_sp", 32'(bus.SP_OUT), 8'h40);
        chk("ld40_empty", 32'(bus.EMPTY), 1);
        bus.PUSH_REQ = 1'b1;
        bus.PUSH_DATA = 10'h2F0;
        @(negedge CLK);
        chk("mid_we", 32'(scr_we), 1);
        old = ram[8'h3F];
        RST_N = 1'b0;
        #1;
        chk("arst_we", 32'(scr_we), 0);
        chk("arst_sp", 32'(bus.SP_OUT), 0);
        chk("arst_busy", 32'(bus.BUSY), 0);
        chk("arst_ack", 32'(bus.ACK), 0);
        bus.PUSH_REQ = 1'b0;
        @(posedge CLK);
        #1;
        chk("arst_ram", 32'(ram[8'h3F]), 32'(old));
        @(negedge CLK);
        RST_N = 1'b1;
        m_sp = 0;
        stk.delete();
        @(negedge CLK);
        idle_chk();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
